// File: rtl/axis_cfg_update_arbiter.sv
// Watches NUM_CH config words and forwards each changed word, tagged with its
// channel index, on one AXI-Stream port; round-robin service with a hold-off gap.
module axis_cfg_update_arbiter #(
    parameter int NUM_CH           = 4,
    parameter int CFG_WIDTH        = 32,
    parameter int IDX_WIDTH        = 2,
    parameter int AXIS_TDATA_WIDTH = 40,
    parameter int HOLDOFF          = 3,
    parameter int INIT_SEND        = 1
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          cfg_enable,
    input  logic [NUM_CH*CFG_WIDTH-1:0]   cfg_data,
    input  logic                          m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic [NUM_CH-1:0]             sts_pending,
    output logic                          sts_busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Counter only ever holds HOLDOFF-1 down to 0.
    localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    logic [1:0]                  state_q, state_d;
    logic [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                        tvalid_q, tvalid_d;
    logic [CFG_WIDTH-1:0]        shadow_q [NUM_CH];
    logic [CFG_WIDTH-1:0]        shadow_d [NUM_CH];
    logic [NUM_CH-1:0]           force_q, force_d;
    logic [IDX_WIDTH-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [NUM_CH-1:0]           sts_pending_q;

    logic [CFG_WIDTH-1:0]        cfg_ch [NUM_CH];
    logic [NUM_CH-1:0]           pending;
    logic                        grant_hit;
    logic [IDX_WIDTH-1:0]        grant_idx;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_ch[i]  = cfg_data[i*CFG_WIDTH +: CFG_WIDTH];
            pending[i] = force_q[i] | (cfg_ch[i] != shadow_q[i]);
        end
    end

    // Walk candidates farthest-first so the nearest one after rr_ptr wins.
    always_comb begin
        int cand;
        grant_hit = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand = (int'(rr_ptr_q) + k) % NUM_CH;
            if (pending[cand]) begin
                grant_hit = 1'b1;
                grant_idx = IDX_WIDTH'(cand);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        shadow_d = shadow_q;
        force_d  = force_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_enable && grant_hit) begin
                    tdata_d                           = '0;
                    tdata_d[CFG_WIDTH-1:0]            = cfg_ch[grant_idx];
                    tdata_d[CFG_WIDTH +: IDX_WIDTH]   = grant_idx;
                    shadow_d[grant_idx]               = cfg_ch[grant_idx];
                    force_d[grant_idx]                = 1'b0;
                    rr_ptr_d                          = grant_idx;
                    tvalid_d                          = 1'b1;
                    state_d                           = ST_SEND;
                end
            end
            ST_SEND: begin
                if (m_axis_tready) begin
                    tvalid_d = 1'b0;
                    if (HOLDOFF == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = CNT_W'(HOLDOFF - 1);
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= ST_IDLE;
            tdata_q       <= '0;
            tvalid_q      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
            force_q       <= (INIT_SEND != 0) ? '1 : '0;
            rr_ptr_q      <= IDX_WIDTH'(NUM_CH - 1);
            cnt_q         <= '0;
            sts_pending_q <= '0;
        end else begin
            state_q       <= state_d;
            tdata_q       <= tdata_d;
            tvalid_q      <= tvalid_d;
            shadow_q      <= shadow_d;
            force_q       <= force_d;
            rr_ptr_q      <= rr_ptr_d;
            cnt_q         <= cnt_d;
            sts_pending_q <= pending;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign sts_pending   = sts_pending_q;
    assign sts_busy      = (state_q != ST_IDLE);

endmodule
